// File: rtl/capi_get_data_pack.sv
`default_nettype none
// ============================================================================
// Module   : capi_get_data_pack
// Purpose  : Packs up to four 128-bit beats into one 512-bit word, with
//            odd-parity checking and stream return-code capture.
// Revision : 1.0
// ============================================================================
module capi_get_data_pack #(
  parameter int rc_width = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_v,
  output logic                i_r,
  input  logic [129:0]        i_d,
  input  logic                i_e,
  input  logic [3:0]          i_c,
  input  logic [rc_width-1:0] i_rc,
  output logic                o_v,
  input  logic                o_r,
  output logic [511:0]        o_d,
  output logic                o_e,
  output logic [5:0]          o_c,
  output logic [rc_width-1:0] o_rc,
  output logic [1:0]          o_perror,
  output logic                o_perr_sticky
);

  logic [1:0]          r_cnt;
  logic [3:0][127:0]   r_asm;
  logic [rc_width-1:0] r_rc;
  logic                r_ov;
  logic [511:0]        r_od;
  logic                r_oe;
  logic [5:0]          r_oc;
  logic [rc_width-1:0] r_orc;
  logic [1:0]          r_perror;
  logic                r_sticky;

  logic                w_ir;
  logic                w_accept;
  logic                w_done;
  logic [511:0]        w_word;
  logic [rc_width-1:0] w_rc;
  logic [5:0]          w_bytes;
  logic [1:0]          w_perr;

  assign w_ir     = ~r_ov | o_r;
  assign w_accept = i_v & w_ir;
  assign w_done   = w_accept & ((r_cnt == 2'd3) | i_e);

  // Stream code latches on the first nonzero value, including the current beat.
  assign w_rc    = (r_rc != '0) ? r_rc : i_rc;
  assign w_bytes = {r_cnt, 4'b0000} + ((i_c == 4'd0) ? 6'd16 : {2'b00, i_c});

  // [1] covers data bits 0..63 (parity bit 128), [0] covers 64..127 (bit 129).
  assign w_perr = {~^{i_d[63:0], i_d[128]}, ~^{i_d[127:64], i_d[129]}};

  // Lanes above the completing beat are zero; lanes below come from assembly.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < 4; k++) begin
      if (2'(k) < r_cnt) begin
        w_word[128*k +: 128] = r_asm[k];
      end else if (2'(k) == r_cnt) begin
        w_word[128*k +: 128] = i_d[127:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 2'd0;
      r_asm <= '0;
      r_rc  <= '0;
    end else if (w_accept) begin
      r_asm[r_cnt] <= i_d[127:0];
      r_cnt        <= w_done ? 2'd0 : r_cnt + 2'd1;
      r_rc         <= (w_done && i_e) ? '0 : w_rc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ov  <= 1'b0;
      r_od  <= '0;
      r_oe  <= 1'b0;
      r_oc  <= 6'd0;
      r_orc <= '0;
    end else if (w_done) begin
      r_ov  <= 1'b1;
      r_od  <= w_word;
      r_oe  <= i_e;
      r_oc  <= i_e ? w_bytes : 6'd0;
      r_orc <= w_rc;
    end else if (o_r) begin
      r_ov <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perror <= 2'b00;
      r_sticky <= 1'b0;
    end else begin
      r_perror <= w_accept ? w_perr : 2'b00;
      r_sticky <= r_sticky | (w_accept & (|w_perr));
    end
  end

  assign i_r           = w_ir;
  assign o_v           = r_ov;
  assign o_d           = r_od;
  assign o_e           = r_oe;
  assign o_c           = r_oc;
  assign o_rc          = r_orc;
  assign o_perror      = r_perror;
  assign o_perr_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_capi_get_data_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_capi_get_data_pack
// Purpose  : Randomized and directed bench with a beat-list reference model.
// Revision : 1.0
// ============================================================================
module tb_capi_get_data_pack;

  localparam int RCW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           i_v = 1'b0;
  logic           i_r;
  logic [129:0]   i_d = '0;
  logic           i_e = 1'b0;
  logic [3:0]     i_c = '0;
  logic [RCW-1:0] i_rc = '0;
  logic           o_v;
  logic           o_r = 1'b0;
  logic [511:0]   o_d;
  logic           o_e;
  logic [5:0]     o_c;
  logic [RCW-1:0] o_rc;
  logic [1:0]     o_perror;
  logic           o_perr_sticky;

  capi_get_data_pack #(.rc_width(RCW)) dut (
    .clk(clk), .reset(reset),
    .i_v(i_v), .i_r(i_r), .i_d(i_d), .i_e(i_e), .i_c(i_c), .i_rc(i_rc),
    .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_e(o_e), .o_c(o_c), .o_rc(o_rc),
    .o_perror(o_perror), .o_perr_sticky(o_perr_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0]   d;
    logic           e;
    logic [5:0]     c;
    logic [RCW-1:0] rc;
  } word_t;

  word_t          exp_q[$];
  logic [127:0]   beats[$];
  logic [RCW-1:0] stream_rc = '0;
  logic [1:0]     exp_perr = 2'b00;
  logic           exp_sticky = 1'b0;
  int             n_checks = 0;
  int             n_fail = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [129:0] mk_beat(input logic [127:0] d, input logic bad0, input logic bad1);
    return {(~^d[127:64]) ^ bad1, (~^d[63:0]) ^ bad0, d};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a falling edge; checks state, drives one cycle, advances the model.
  task automatic cycle(input logic v, input logic [127:0] data, input logic bad0,
                       input logic bad1, input logic e, input logic [3:0] c,
                       input logic [RCW-1:0] rc, input logic ordy);
    word_t w;
    logic  exp_ov, exp_ir, acc;
    int    n;
    exp_ov = (exp_q.size() != 0);
    check_eq("o_v", 512'(o_v), 512'(exp_ov));
    check_eq("o_perror", 512'(o_perror), 512'(exp_perr));
    check_eq("o_perr_sticky", 512'(o_perr_sticky), 512'(exp_sticky));
    if (exp_ov) begin
      check_eq("o_d", o_d, exp_q[0].d);
      check_eq("o_e", 512'(o_e), 512'(exp_q[0].e));
      check_eq("o_c", 512'(o_c), 512'(exp_q[0].c));
      check_eq("o_rc", 512'(o_rc), 512'(exp_q[0].rc));
    end
    i_v  = v;
    i_d  = mk_beat(data, bad0, bad1);
    i_e  = e;
    i_c  = c;
    i_rc = rc;
    o_r  = ordy;
    #1;
    exp_ir = !exp_ov || ordy;
    check_eq("i_r", 512'(i_r), 512'(exp_ir));
    acc = v && exp_ir;
    if (exp_ov && ordy) void'(exp_q.pop_front());
    exp_perr   = acc ? {bad0, bad1} : 2'b00;
    exp_sticky = exp_sticky | (acc & (bad0 | bad1));
    if (acc) begin
      beats.push_back(data);
      if (stream_rc == '0) stream_rc = rc;
      if (beats.size() == 4 || e) begin
        n = beats.size();
        w.d = '0;
        foreach (beats[k]) w.d[128*k +: 128] = beats[k];
        w.e  = e;
        w.c  = e ? 6'((16 * (n - 1) + ((c == 4'd0) ? 16 : int'(c))) % 64) : 6'd0;
        w.rc = stream_rc;
        exp_q.push_back(w);
        beats.delete();
        if (e) stream_rc = '0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    i_v   = 1'b0;
    o_r   = 1'b0;
    #1;
    check_eq("rst o_v", 512'(o_v), 512'(0));
    check_eq("rst o_d", o_d, 512'(0));
    check_eq("rst o_e", 512'(o_e), 512'(0));
    check_eq("rst o_c", 512'(o_c), 512'(0));
    check_eq("rst o_rc", 512'(o_rc), 512'(0));
    check_eq("rst o_perror", 512'(o_perror), 512'(0));
    check_eq("rst o_perr_sticky", 512'(o_perr_sticky), 512'(0));
    exp_q.delete();
    beats.delete();
    stream_rc  = '0;
    exp_perr   = 2'b00;
    exp_sticky = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, '0, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    idle(2);

    // Eight-beat full stream with no back-pressure.
    for (int k = 0; k < 8; k++) cycle(1'b1, rnd128(), 1'b0, 1'b0, k == 7, 4'd0, '0, 1'b1);
    idle(2);

    // Short end word: three beats, five bytes in the last.
    for (int k = 0; k < 3; k++) cycle(1'b1, rnd128(), 1'b0, 1'b0, k == 2, 4'd5, '0, 1'b1);
    idle(2);

    // Back-pressure on a pending word, then release with a beat waiting.
    for (int k = 0; k < 4; k++) cycle(1'b1, rnd128(), 1'b0, 1'b0, 1'b0, 4'd0, '0, 1'b0);
    for (int k = 0; k < 10; k++) cycle(1'b1, rnd128(), 1'b0, 1'b0, 1'b0, 4'd0, '0, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b1, rnd128(), 1'b0, 1'b0, k == 3, 4'd0, '0, 1'b1);
    idle(2);

    // Return-code capture across words, cleared for the following stream.
    for (int k = 0; k < 8; k++)
      cycle(1'b1, rnd128(), 1'b0, 1'b0, k == 7, 4'd0,
            (k == 1) ? RCW'(1) : ((k == 5) ? RCW'(2) : RCW'(0)), 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b1, rnd128(), 1'b0, 1'b0, k == 3, 4'd0, '0, 1'b1);
    idle(2);

    // Parity error on the low data half.
    cycle(1'b1, rnd128(), 1'b1, 1'b0, 1'b0, 4'd0, '0, 1'b1);
    cycle(1'b1, rnd128(), 1'b0, 1'b0, 1'b1, 4'd9, '0, 1'b1);
    idle(3);

    // Reset in the middle of a stream, then a fresh four-beat stream.
    cycle(1'b1, rnd128(), 1'b0, 1'b0, 1'b0, 4'd0, '0, 1'b1);
    cycle(1'b1, rnd128(), 1'b0, 1'b0, 1'b0, 4'd0, '0, 1'b1);
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b1, rnd128(), 1'b0, 1'b0, k == 3, 4'd0, '0, 1'b1);
    idle(2);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 9) < 8, rnd128(),
              $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)),
              ($urandom_range(0, 9) == 0) ? RCW'($urandom_range(1, 3)) : RCW'(0),
              $urandom_range(0, 9) < 7);
      end
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
